// File: rtl/l1_line_cache_if.sv
// Wishbone-style 128-bit line bus shared by the CPU-side and memory-side ports.
// Carries the request (CYC/STB/WE/ADR/SEL/DAT_M) and the response (DAT_S/ACK).
// The master modport issues requests; the slave modport answers them.
interface l1_line_cache_if;
    logic         CYC;
    logic         STB;
    logic         WE;
    logic [11:0]  ADR;
    logic [15:0]  SEL;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic         ACK;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK
    );
endinterface

// File: rtl/l1_line_cache.sv
// Direct-mapped write-back/write-allocate line cache; hits ACK combinationally in the request cycle.
// Miss: optional writeback (WB) then refill (FILL) on the mem port, then the request hits in IDLE.
// Ports: clk, rst (async, active-high), cpu (slave line bus), mem (master line bus), hit/miss counters.
module l1_line_cache #(
    parameter int NUM_SETS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    l1_line_cache_if.slave        cpu,
    l1_line_cache_if.master       mem,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int IDX  = $clog2(NUM_SETS);
    localparam int TAGW = 12 - IDX;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, dirty_q;
    logic [TAGW-1:0]     tag_q  [NUM_SETS];
    logic [127:0]        line_q [NUM_SETS];
    logic [15:0]         hit_count_q, miss_count_q;

    logic                req, hit, ack, wr_hit, miss, wb_done, fill_done;
    logic [IDX-1:0]      idx;
    logic [TAGW-1:0]     cpu_tag;
    logic [127:0]        line_cur, merged;

    assign req      = cpu.CYC & cpu.STB;
    assign idx      = cpu.ADR[IDX-1:0];
    assign cpu_tag  = cpu.ADR[11:IDX];
    assign line_cur = line_q[idx];
    assign hit      = req & valid_q[idx] & (tag_q[idx] == cpu_tag);

    assign ack       = (state_q == ST_IDLE) & hit;
    assign wr_hit    = ack & cpu.WE;
    assign miss      = (state_q == ST_IDLE) & req & ~hit;
    assign wb_done   = (state_q == ST_WB)   & mem.ACK;
    assign fill_done = (state_q == ST_FILL) & mem.ACK;

    assign cpu.ACK   = ack;
    assign cpu.DAT_S = line_cur;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Byte-granular merge of write data into the currently indexed line.
    always_comb begin
        merged = line_cur;
        for (int i = 0; i < 16; i++) begin
            if (cpu.SEL[i]) begin
                merged[8*i +: 8] = cpu.DAT_M[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = (valid_q[idx] & dirty_q[idx]) ? ST_WB : ST_FILL;
                end
            end
            ST_WB:   if (mem.ACK) state_d = ST_FILL;
            ST_FILL: if (mem.ACK) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side drive. Address tracks the CPU address except during
    // writeback, where it is rebuilt from the victim's stored tag.
    always_comb begin
        mem.CYC   = 1'b0;
        mem.STB   = 1'b0;
        mem.WE    = 1'b0;
        mem.SEL   = 16'h0000;
        mem.ADR   = cpu.ADR;
        mem.DAT_M = line_cur;
        case (state_q)
            ST_WB: begin
                mem.CYC = 1'b1;
                mem.STB = 1'b1;
                mem.WE  = 1'b1;
                mem.SEL = 16'hFFFF;
                mem.ADR = {tag_q[idx], idx};
            end
            ST_FILL: begin
                mem.CYC = 1'b1;
                mem.STB = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (ack)  hit_count_q  <= hit_count_q + 16'd1;
            if (miss) miss_count_q <= miss_count_q + 16'd1;
            // A write hit marks the line dirty even with no byte enables set.
            if (wr_hit)  dirty_q[idx] <= 1'b1;
            if (wb_done) dirty_q[idx] <= 1'b0;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset. During reset the FSM sits in IDLE
    // and every line is invalid, so neither write enable can fire.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            line_q[idx] <= merged;
        end
        if (fill_done) begin
            line_q[idx] <= mem.DAT_S;
            tag_q[idx]  <= cpu_tag;
        end
    end
endmodule

// File: doc/l1_line_cache.md
# l1_line_cache

Direct-mapped, write-back, write-allocate line cache that serves as the wishbone responder for one of the datapath's master ports (ifetch or memory). It accepts 128-bit line requests with byte selects on its CPU-side slave port and returns hits combinationally in the request cycle. On a miss it evicts and refills through a wishbone master port toward the next memory level. One instance is placed per datapath port.

## Interface
- NUM_SETS, 8, number of lines; power of two, at least 2. IDX = log2(NUM_SETS); tag width = 12 − IDX.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_CYC, cpu_STB  in  1 each  request valid when both are high.
- cpu_WE  in  1  1 = write, 0 = read.
- cpu_ADR  in  12  line address. Index = cpu_ADR[IDX-1:0]; tag = cpu_ADR[11:IDX].
- cpu_SEL  in  16  byte enables; bit i covers DAT bits [8i+7:8i].
- cpu_DAT_M  in  128  write data.
- cpu_DAT_S  out  128  data line at the current index (combinational).
- cpu_ACK  out  1  request completes this cycle (combinational).
- mem_CYC, mem_STB  out  1 each  memory request.
- mem_WE  out  1  memory write (writeback).
- mem_ADR  out  12  memory line address.
- mem_SEL  out  16  all ones during writeback, all zeros otherwise.
- mem_DAT_M  out  128  victim line data.
- mem_DAT_S  in  128  fill data.
- mem_ACK  in  1  memory completes this cycle.
- hit_count, miss_count  out  16 each  performance counters.

## Operation
- Storage per set: valid bit, dirty bit, tag, and a 128-bit line.
  - rst clears valid, dirty and both counters.
  - Tag and data arrays are not reset.
- hit = req & valid[idx] & (tag[idx] == cpu tag), where req = cpu_CYC & cpu_STB.
- FSM states: IDLE, WB, FILL. Reset state is IDLE.
- IDLE
  - cpu_ACK = hit.
  - Read hit: cpu_DAT_S is the stored line; no state change.
  - Write hit: at the clock edge, each byte with cpu_SEL[i] = 1 takes cpu_DAT_M; other bytes hold. dirty[idx] is set to 1, including when cpu_SEL = 0.
  - req & !hit: if valid[idx] & dirty[idx], go to WB; otherwise go to FILL. miss_count increments.
- WB
  - mem_CYC = mem_STB = mem_WE = 1, mem_SEL = 16'hFFFF.
  - mem_ADR = {tag[idx], idx}; mem_DAT_M = line[idx].
  - On mem_ACK: dirty[idx] is cleared and the FSM goes to FILL.
- FILL
  - mem_CYC = mem_STB = 1, mem_WE = 0, mem_ADR = cpu_ADR.
  - On mem_ACK: line[idx] is loaded from mem_DAT_S, tag[idx] from the cpu tag, valid = 1, dirty = 0. The FSM goes to IDLE.
  - The original request then hits in IDLE. A write miss completes as a write hit on that cycle.
- cpu_ACK is 0 in WB and FILL.
- Outside WB and FILL, all mem_ strobes are 0. In IDLE, mem_ADR = cpu_ADR.
- hit_count increments on every cpu_ACK cycle, including the post-fill completion of a miss.
- Both counters wrap from 0xFFFF to 0x0000.

## Timing
- Reset values: cpu_ACK 0, mem_CYC/STB/WE 0, mem_SEL 0, hit_count 0, miss_count 0. cpu_DAT_S, mem_ADR and mem_DAT_M are don't-care.
- Hit latency: 0 cycles. ACK is asserted in the request cycle, so back-to-back hits sustain one line per cycle.
- Clean miss: the request is seen in cycle 0; FILL runs from cycle 1. If mem_ACK arrives in cycle k, cpu_ACK is asserted in cycle k+1.
- Dirty miss: WB runs from cycle 1. If mem_ACK arrives in cycle j, FILL runs from j+1. If the fill ACK arrives in cycle k, cpu_ACK is asserted in cycle k+1.
- The master holds cpu_ADR, cpu_WE, cpu_SEL and cpu_DAT_M stable until cpu_ACK.
- Dropping req mid-miss does not abort the transfer: WB and FILL run to completion and the FSM returns to IDLE.
- mem_ACK is ignored in IDLE.
- rst asserted mid-WB or mid-FILL: FSM goes to IDLE and mem strobes drop in the same cycle (asynchronous). The outstanding memory transfer is abandoned and all lines become invalid.

## Test plan
- Test plan uses NUM_SETS = 8.
- Reset, then read of ADR 0x012 -> FILL with mem_ADR 0x012. Memory ACKs after 3 cycles with line 0x…AA. One cycle later cpu_ACK = 1 and cpu_DAT_S = 0x…AA. miss_count = 1, hit_count = 1.
- Repeat read of 0x012 -> cpu_ACK in the same cycle with no mem_CYC. hit_count = 2.
- Write to 0x012 with SEL = 16'h0003 and DAT_M low half-word 0xBEEF -> ACK the same cycle. The line reads back with bytes 0–1 = 0xBEEF and all other bytes unchanged. dirty = 1.
- Read of 0x01A (same index, tag 3) -> WB with mem_ADR 0x012, mem_WE = 1, SEL = FFFF, and the modified line as data. Then FILL with mem_ADR 0x01A, then ACK. miss_count increments by 1.
- Write miss to 0x005 with SEL = FFFF -> FILL, then ACK on the following IDLE cycle. The written data overrides the fill data; dirty = 1.
- rst asserted while in FILL -> mem_CYC = 0 immediately. A later read of 0x01A misses again.
- Drive 65 536 hits -> hit_count wraps to 0 (relative to its value before the burst).
